// File: rtl/booth_arb_defs.sv
// ---------------------------------------------------------------------------
// booth_arb_defs
// Shared definitions for the two-requester multiplier arbiter:
//   NUM_REQ        number of requesters sharing the multiplier
//   arb_state_t    arbiter FSM state encoding
//   idx_to_onehot  converts a requester index into a one-hot vector
// ---------------------------------------------------------------------------
package booth_arb_defs;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant selection (purely combinational).
// Ports:
//   req  [1:0]  request vector
//   last        index of the requester granted most recently
//   gnt  [1:0]  one-hot grant, zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         // Contention: the requester that did not win last time goes first.
         gnt = last ? 2'b01 : 2'b10;
      end else begin
         // Zero or one request pending: it is already one-hot (or zero).
         gnt = req;
      end
   end

endmodule

// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
// Shares one external multiplier between two requesters. A request is
// accepted in IDLE, its operands are registered onto mul_in1/mul_in2, a
// single mul_start pulse is issued, and the product (or zero on timeout) is
// returned to the owning requester with a valid/ready handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready[1:0] request handshake, req_ready one-hot or zero
//   req_a/req_b              packed operands, requester i at [i*BIT_LEN +: BIT_LEN]
//   rsp_valid/rsp_ready[1:0] response handshake, rsp_valid one-hot or zero
//   rsp_data                 signed product for the flagged requester
//   mul_in1/mul_in2          registered multiplier operands
//   mul_start                one-cycle multiplier start pulse
//   mul_out/mul_out_r        multiplier product and its ready flag
//   err_timeout              sticky: multiplier missed the TIMEOUT deadline
// ---------------------------------------------------------------------------
module booth_mul_arbiter
   import booth_arb_defs::*;
#(
   parameter int BIT_LEN = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*BIT_LEN-1:0]   req_a,
   input  logic [NUM_REQ*BIT_LEN-1:0]   req_b,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [2*BIT_LEN-1:0]         rsp_data,
   output logic [BIT_LEN-1:0]           mul_in1,
   output logic [BIT_LEN-1:0]           mul_in2,
   output logic                         mul_start,
   input  logic [2*BIT_LEN-1:0]         mul_out,
   input  logic                         mul_out_r,
   output logic                         err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t             state_q, state_d;
   logic                   gnt_q, gnt_d;       // index of requester being served
   logic                   last_q, last_d;     // index of last completed grant
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       cnt_inc;
   logic [BIT_LEN-1:0]     mul_in1_q, mul_in1_d;
   logic [BIT_LEN-1:0]     mul_in2_q, mul_in2_d;
   logic [2*BIT_LEN-1:0]   rsp_data_q, rsp_data_d;
   logic                   err_q, err_d;
   logic [NUM_REQ-1:0]     arb_gnt;

   // Per-requester operand views of the packed input buses.
   logic [BIT_LEN-1:0]     a_slice [NUM_REQ];
   logic [BIT_LEN-1:0]     b_slice [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_slice[gi] = req_a[gi*BIT_LEN +: BIT_LEN];
      assign b_slice[gi] = req_b[gi*BIT_LEN +: BIT_LEN];
   end

   rr_arb2 u_rr_arb2 (
      .req  (req_valid),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      mul_in1_d  = mul_in1_q;
      mul_in2_d  = mul_in2_q;
      rsp_data_d = rsp_data_q;
      err_d      = err_q;
      cnt_inc    = cnt_q + CNT_W'(1);
      req_ready  = '0;
      rsp_valid  = '0;
      mul_start  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = arb_gnt;
            if (|(req_valid & arb_gnt)) begin
               gnt_d     = arb_gnt[1];
               mul_in1_d = a_slice[arb_gnt[1]];
               mul_in2_d = b_slice[arb_gnt[1]];
               state_d   = ST_START;
            end
         end
         ST_START: begin
            mul_start = 1'b1;
            cnt_d     = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            // A result arriving on the deadline cycle still wins over timeout.
            if (mul_out_r) begin
               rsp_data_d = mul_out;
               state_d    = ST_RESP;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               err_d      = 1'b1;
               rsp_data_d = '0;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = idx_to_onehot(gnt_q);
            if (rsp_ready[gnt_q]) begin
               last_d  = gnt_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;   // requester 0 wins the first contention
         cnt_q      <= '0;
         mul_in1_q  <= '0;
         mul_in2_q  <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         mul_in1_q  <= mul_in1_d;
         mul_in2_q  <= mul_in2_d;
         rsp_data_q <= rsp_data_d;
         err_q      <= err_d;
      end
   end

   assign mul_in1     = mul_in1_q;
   assign mul_in2     = mul_in2_q;
   assign rsp_data    = rsp_data_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_arbiter
// Transaction-level bench: the bench plays both requesters and the external
// multiplier. Expected grants, products, latencies and the sticky error flag
// come from a small model (pending flags, last winner, signed arithmetic).
// ---------------------------------------------------------------------------
module tb_booth_mul_arbiter;

   localparam int W   = 4;
   localparam int PW  = 2 * W;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [PW-1:0] req_a;
   logic [PW-1:0] req_b;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [PW-1:0] rsp_data;
   logic [W-1:0]  mul_in1;
   logic [W-1:0]  mul_in2;
   logic          mul_start;
   logic [PW-1:0] mul_out;
   logic          mul_out_r;
   logic          err_timeout;

   booth_mul_arbiter #(.BIT_LEN(W), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .mul_in1     (mul_in1),
      .mul_in2     (mul_in2),
      .mul_start   (mul_start),
      .mul_out     (mul_out),
      .mul_out_r   (mul_out_r),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Model state
   int          n_vec  = 0;
   int          n_err  = 0;
   int          n_txn  = 0;
   logic [1:0]  pending;
   logic [W-1:0] op_a [2];
   logic [W-1:0] op_b [2];
   int          last_m;
   logic        err_m;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] onehot(input int i);
      return (i == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [PW-1:0] sa;
      logic signed [PW-1:0] sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      req_valid = pending;
      req_a     = {op_a[1], op_a[0]};
      req_b     = {op_b[1], op_b[0]};
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
      check_eq({tag, "_mul_in1"},   32'(mul_in1),   32'd0);
      check_eq({tag, "_mul_in2"},   32'(mul_in2),   32'd0);
      check_eq({tag, "_mul_start"}, 32'(mul_start), 32'd0);
      check_eq({tag, "_err"},       32'(err_timeout), 32'd0);
   endtask

   // One full transaction starting in IDLE. mul_delay < 0 means the
   // multiplier never answers; hold is the number of cycles rsp_ready[g]
   // is withheld (the other requester's ready bit is raised meanwhile).
   task automatic run_round(input int mul_delay, input int hold);
      int            g;
      logic [PW-1:0] exp_p;
      drive_reqs();
      #1;
      if (pending == 2'b11) g = (last_m == 1) ? 0 : 1;
      else                  g = pending[1] ? 1 : 0;
      check_eq("grant", 32'(req_ready), 32'(onehot(g)));
      exp_p = prod(op_a[g], op_b[g]);
      step();                                   // START
      pending[g] = 1'b0;
      drive_reqs();
      #1;
      check_eq("start_pulse", 32'(mul_start), 32'd1);
      check_eq("mul_in1", 32'(mul_in1), 32'(op_a[g]));
      check_eq("mul_in2", 32'(mul_in2), 32'(op_b[g]));
      check_eq("busy_ready", 32'(req_ready), 32'd0);
      step();                                   // first WAIT cycle
      check_eq("start_single", 32'(mul_start), 32'd0);
      if (mul_delay < 0) begin
         for (int k = 0; k < TMO; k++) begin
            mul_out = PW'($urandom);
            check_eq("wait_no_rsp", 32'(rsp_valid), 32'd0);
            step();
         end
         err_m = 1'b1;
         exp_p = '0;
      end else begin
         for (int k = 0; k < mul_delay; k++) begin
            mul_out = PW'($urandom);
            check_eq("wait_no_rsp", 32'(rsp_valid), 32'd0);
            step();
         end
         mul_out_r = 1'b1;
         mul_out   = prod(mul_in1, mul_in2);
         step();
         mul_out_r = 1'b0;
         mul_out   = PW'($urandom);
      end
      #1;
      for (int h = 0; h <= hold; h++) begin
         check_eq("rsp_valid", 32'(rsp_valid), 32'(onehot(g)));
         check_eq("rsp_data", 32'(rsp_data), 32'(exp_p));
         check_eq("err_timeout", 32'(err_timeout), 32'(err_m));
         check_eq("resp_ready_blocked", 32'(req_ready), 32'd0);
         if (h < hold) begin
            rsp_ready = onehot(1 - g);
            step();
         end else begin
            rsp_ready = onehot(g);
         end
      end
      step();                                   // back in IDLE
      rsp_ready = 2'b00;
      last_m    = g;
      #1;
      check_eq("rsp_done", 32'(rsp_valid), 32'd0);
      n_txn++;
      $display("txn %0d: req%0d a=%h b=%h -> rsp_data=%h err=%0d", n_txn, g, op_a[g], op_b[g], exp_p, err_m);
   endtask

   initial begin
      rst       = 1'b1;
      pending   = 2'b00;
      op_a[0] = '0; op_a[1] = '0; op_b[0] = '0; op_b[1] = '0;
      rsp_ready = 2'b00;
      mul_out   = '0;
      mul_out_r = 1'b0;
      last_m    = 1;
      err_m     = 1'b0;
      drive_reqs();
      #2;
      check_outputs_zero("reset");
      step();
      step();
      rst = 1'b0;

      // Both requesters valid from reset: req0 (3*2) first, then req1 (-4*-4).
      op_a[0] = 4'd3; op_b[0] = 4'd2;
      op_a[1] = 4'hC; op_b[1] = 4'hC;
      pending = 2'b11;
      run_round(0, 0);
      run_round(2, 0);

      // Req0 alone: 7 * -5 = -35.
      op_a[0] = 4'b0111; op_b[0] = 4'b1011;
      pending = 2'b01;
      run_round(1, 0);

      // Response held off for 10 cycles while the other requester waits.
      op_a[0] = W'($urandom); op_b[0] = W'($urandom);
      op_a[1] = W'($urandom); op_b[1] = W'($urandom);
      pending = 2'b11;
      run_round(1, 10);
      while (pending != 2'b00) run_round(0, 0);

      // Spurious mul_out_r while idle must be ignored.
      drive_reqs();
      mul_out_r = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mul_out = PW'($urandom);
         #1;
         check_eq("idle_spurious_rsp", 32'(rsp_valid), 32'd0);
         check_eq("idle_spurious_start", 32'(mul_start), 32'd0);
         step();
      end
      mul_out_r = 1'b0;

      // Multiplier never answers: timeout, zero result, sticky flag.
      op_a[1] = 4'd5; op_b[1] = 4'd5;
      pending = 2'b10;
      run_round(-1, 0);

      // Randomized traffic.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
               pending[i] = 1'b1;
               op_a[i] = W'($urandom);
               op_b[i] = W'($urandom);
            end
         end
         if (pending == 2'b00) begin
            pending[$urandom_range(0, 1)] = 1'b1;
         end
         run_round(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 3)));
      end
      while (pending != 2'b00) run_round(0, 0);
      check_eq("err_sticky", 32'(err_timeout), 32'd1);

      // Reset during WAIT aborts the transaction with no response.
      op_a[1] = 4'd6; op_b[1] = 4'd7;
      pending = 2'b10;
      drive_reqs();
      #1;
      check_eq("pre_abort_grant", 32'(req_ready), 32'b10);
      step();
      pending = 2'b00;
      drive_reqs();
      step();
      step();
      rst = 1'b1;
      #1;
      check_outputs_zero("abort");
      step();
      check_outputs_zero("abort_edge");
      rst    = 1'b0;
      last_m = 1;
      err_m  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
         step();
      end

      // After reset requester 0 wins contention again.
      for (int i = 0; i < 2; i++) begin
         op_a[i] = W'($urandom);
         op_b[i] = W'($urandom);
      end
      pending = 2'b11;
      run_round(3, 1);
      run_round(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
